// File: rtl/eproj_wing_controller_pkg.sv
// Shared definitions for the enemy wing: default wing sizes, the per-ship
// state encoding, and the inclusive-exclusive span test used by the raster
// on-tests.
package galaga_lib;

  localparam int NS  = 4;  // enemy ships in the wing
  localparam int NPE = 8;  // projectile slots shared by the wing

  typedef enum logic [1:0] {
    ST_ENTER = 2'd0,
    ST_FORM  = 2'd1,
    ST_DEAD  = 2'd2
  } ship_state_e;

  // lo <= pt < lo + size, evaluated on 11 bits so objects near the right or
  // bottom edge of the 10-bit space never wrap back to column/row 0.
  function automatic logic in_span(input logic [9:0]  lo,
                                   input logic [9:0]  pt,
                                   input logic [10:0] size);
    return ({1'b0, pt} >= {1'b0, lo}) && ({1'b0, pt} < ({1'b0, lo} + size));
  endfunction

endpackage

// File: rtl/eproj_wing_controller_eship_unit.sv
// One enemy ship: ENTER/FORM/DEAD state machine plus respawn down-counter.
// Ports:
//   frame_clk         frame-rate clock
//   rst               asynchronous active-high reset
//   init_x, init_y    spawn point (used at reset and on respawn)
//   sched_x, sched_y  formation target for this frame
//   coll              hit by a player projectile
//   state             current ship state
//   pos_x, pos_y      current (pre-update) ship position
module eship_unit
  import galaga_lib::*;
#(
  parameter int SHIP_STEP = 2,
  parameter int RESPAWN   = 120
) (
  input  logic        frame_clk,
  input  logic        rst,
  input  logic [9:0]  init_x,
  input  logic [9:0]  init_y,
  input  logic [9:0]  sched_x,
  input  logic [9:0]  sched_y,
  input  logic        coll,
  output ship_state_e state,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y
);

  localparam int                 CNT_W    = $clog2(RESPAWN + 1);
  localparam logic signed [11:0] STEP_S   = 12'(SHIP_STEP);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(RESPAWN - 1);

  ship_state_e      state_q, state_d;
  logic [9:0]       x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fresh_q, fresh_d;
  logic [9:0]       cur_x, cur_y;

  // Reset cannot load a live input into a flop cleanly, so after reset the
  // position is taken straight from the spawn inputs until the first frame
  // edge captures it.
  assign cur_x = fresh_q ? init_x : x_q;
  assign cur_y = fresh_q ? init_y : y_q;
  assign pos_x = cur_x;
  assign pos_y = cur_y;
  assign state = state_q;

  function automatic logic signed [11:0] diff(input logic [9:0] cur, input logic [9:0] tgt);
    return $signed({2'b00, tgt}) - $signed({2'b00, cur});
  endfunction

  function automatic logic near(input logic [9:0] cur, input logic [9:0] tgt);
    return (diff(cur, tgt) <= STEP_S) && (diff(cur, tgt) >= -STEP_S);
  endfunction

  // One step toward the target; within a step it lands exactly on it.
  function automatic logic [9:0] step_toward(input logic [9:0] cur, input logic [9:0] tgt);
    if (diff(cur, tgt) > STEP_S)  return cur + 10'(SHIP_STEP);
    if (diff(cur, tgt) < -STEP_S) return cur - 10'(SHIP_STEP);
    return tgt;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    x_d     = cur_x;
    y_d     = cur_y;
    cnt_d   = cnt_q;
    fresh_d = 1'b0;
    case (state_q)
      ST_ENTER: begin
        if (coll) begin
          state_d = ST_DEAD;
          cnt_d   = CNT_LOAD;
        end else begin
          x_d = step_toward(cur_x, sched_x);
          y_d = step_toward(cur_y, sched_y);
          if (near(cur_x, sched_x) && near(cur_y, sched_y)) state_d = ST_FORM;
        end
      end
      ST_FORM: begin
        if (coll) begin
          state_d = ST_DEAD;
          cnt_d   = CNT_LOAD;
        end else begin
          x_d = sched_x;
          y_d = sched_y;
        end
      end
      ST_DEAD: begin
        // Hits are ignored while dead; only the counter matters.
        if (cnt_q == '0) begin
          state_d = ST_ENTER;
          x_d     = init_x;
          y_d     = init_y;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_ENTER;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of block ordering.
  always_ff @(posedge frame_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ENTER;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      fresh_q <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      fresh_q <= fresh_d;
    end
  end

endmodule

// File: rtl/eproj_wing_controller.sv
// Enemy wing controller: NS ships (eship_unit each) sharing NPE projectile
// slots. Fire requests from formed ships are served in ship order into the
// lowest free slot; live projectiles fall until they hit the player or leave
// the screen. Combinational raster on-tests and offsets feed the renderer.
// Ports:
//   frame_clk, Reset               frame clock, async active-high reset
//   DrawX, DrawY                   current raster pixel
//   EShipInitialX/Y                shared spawn point
//   ESchedX/Y, ESchedFire          per-ship formation target and fire request
//   EShipColl, EProjColl           ship hit / projectile hit player
//   EShipOn, EShipDistX/Y          ship on-pixel flags and lowest-index offset
//   EProjOn, EProjDistX/Y          projectile on-pixel flags and offset
//   EShipAlive                     ship in ENTER or FORM
//   EProjDrop                      a fire request found no free slot
module eproj_wing_controller #(
  parameter int NS            = galaga_lib::NS,
  parameter int NPE           = galaga_lib::NPE,
  parameter int SHIP_SIZE     = 16,
  parameter int PROJ_SIZE     = 4,
  parameter int SHIP_STEP     = 2,
  parameter int PROJ_STEP     = 4,
  parameter int RESPAWN       = 120,
  parameter int SCREEN_BOTTOM = 479
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic [9:0]           EShipInitialX,
  input  logic [9:0]           EShipInitialY,
  input  logic [NS-1:0][9:0]   ESchedX,
  input  logic [NS-1:0][9:0]   ESchedY,
  input  logic [NS-1:0]        ESchedFire,
  input  logic [NS-1:0]        EShipColl,
  input  logic [NPE-1:0]       EProjColl,
  output logic [NS-1:0]        EShipOn,
  output logic [9:0]           EShipDistX,
  output logic [9:0]           EShipDistY,
  output logic [NPE-1:0]       EProjOn,
  output logic [9:0]           EProjDistX,
  output logic [9:0]           EProjDistY,
  output logic [NS-1:0]        EShipAlive,
  output logic                 EProjDrop
);

  galaga_lib::ship_state_e ship_state [NS];
  logic [9:0]              ship_x [NS];
  logic [9:0]              ship_y [NS];

  for (genvar g = 0; g < NS; g++) begin : g_ship
    eship_unit #(
      .SHIP_STEP (SHIP_STEP),
      .RESPAWN   (RESPAWN)
    ) u_ship (
      .frame_clk (frame_clk),
      .rst       (Reset),
      .init_x    (EShipInitialX),
      .init_y    (EShipInitialY),
      .sched_x   (ESchedX[g]),
      .sched_y   (ESchedY[g]),
      .coll      (EShipColl[g]),
      .state     (ship_state[g]),
      .pos_x     (ship_x[g]),
      .pos_y     (ship_y[g])
    );
    assign EShipAlive[g] = (ship_state[g] != galaga_lib::ST_DEAD);
  end

  logic [NPE-1:0] live_q, live_d;
  logic [9:0]     px_q [NPE];
  logic [9:0]     px_d [NPE];
  logic [9:0]     py_q [NPE];
  logic [9:0]     py_d [NPE];
  logic           drop_q, drop_d;
  logic [NPE-1:0] free_slots;
  logic           found;

  always_comb begin
    live_d = live_q;
    px_d   = px_q;
    py_d   = py_q;
    drop_d = 1'b0;
    found  = 1'b0;
    // Only slots free before this edge are offered, so a slot released this
    // frame waits one frame before reuse.
    free_slots = ~live_q;

    for (int j = 0; j < NPE; j++) begin
      if (live_q[j]) begin
        if (EProjColl[j]) begin
          live_d[j] = 1'b0;
        end else if ({1'b0, py_q[j]} + 11'(PROJ_STEP) > 11'(SCREEN_BOTTOM)) begin
          live_d[j] = 1'b0;
        end else begin
          py_d[j] = py_q[j] + 10'(PROJ_STEP);
        end
      end
    end

    // Fire eligibility uses the pre-update state, so a formed ship that is
    // hit on this edge still launches.
    for (int i = 0; i < NS; i++) begin
      if (ESchedFire[i] && ship_state[i] == galaga_lib::ST_FORM) begin
        found = 1'b0;
        for (int j = 0; j < NPE; j++) begin
          if (!found && free_slots[j]) begin
            found         = 1'b1;
            free_slots[j] = 1'b0;
            live_d[j]     = 1'b1;
            px_d[j]       = ship_x[i] + 10'(SHIP_SIZE / 2 - PROJ_SIZE / 2);
            py_d[j]       = ship_y[i] + 10'(SHIP_SIZE);
          end
        end
        if (!found) drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      live_q <= '0;
      drop_q <= 1'b0;
      // NOTE: slot positions are a small register array with a defined reset
      // value, so they are reset explicitly rather than left as RAM.
      for (int j = 0; j < NPE; j++) begin
        px_q[j] <= '0;
        py_q[j] <= '0;
      end
    end else begin
      live_q <= live_d;
      drop_q <= drop_d;
      px_q   <= px_d;
      py_q   <= py_d;
    end
  end

  assign EProjDrop = drop_q;

  // Raster on-tests; the descending scan leaves the lowest-index hit's offset.
  always_comb begin
    EShipOn    = '0;
    EShipDistX = '0;
    EShipDistY = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      EShipOn[i] = EShipAlive[i]
                 && galaga_lib::in_span(ship_x[i], DrawX, 11'(SHIP_SIZE))
                 && galaga_lib::in_span(ship_y[i], DrawY, 11'(SHIP_SIZE));
      if (EShipOn[i]) begin
        EShipDistX = DrawX - ship_x[i];
        EShipDistY = DrawY - ship_y[i];
      end
    end
  end

  always_comb begin
    EProjOn    = '0;
    EProjDistX = '0;
    EProjDistY = '0;
    for (int j = NPE - 1; j >= 0; j--) begin
      EProjOn[j] = live_q[j]
                 && galaga_lib::in_span(px_q[j], DrawX, 11'(PROJ_SIZE))
                 && galaga_lib::in_span(py_q[j], DrawY, 11'(PROJ_SIZE));
      if (EProjOn[j]) begin
        EProjDistX = DrawX - px_q[j];
        EProjDistY = DrawY - py_q[j];
      end
    end
  end

endmodule

// File: tb/tb_eproj_wing_controller.sv
// Self-checking bench for eproj_wing_controller: a frame-level behavioural
// model of ships and projectile slots is compared against the DUT every
// frame, plus directed literal checks of the key scenarios.
module tb_eproj_wing_controller;

  localparam int NS = 4, NPE = 8, SHIP_SIZE = 16, PROJ_SIZE = 4;
  localparam int SHIP_STEP = 2, PROJ_STEP = 4, RESPAWN = 120, BOTTOM = 479;
  localparam int M_ENTER = 0, M_FORM = 1, M_DEAD = 2;

  logic               frame_clk = 1'b0;
  logic               Reset;
  logic [9:0]         DrawX, DrawY, init_x, init_y;
  logic [NS-1:0][9:0] sched_x, sched_y;
  logic [NS-1:0]      fire, scoll;
  logic [NPE-1:0]     pcoll;
  logic [NS-1:0]      EShipOn, EShipAlive;
  logic [9:0]         EShipDistX, EShipDistY, EProjDistX, EProjDistY;
  logic [NPE-1:0]     EProjOn;
  logic               EProjDrop;

  eproj_wing_controller dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .EShipInitialX (init_x),
    .EShipInitialY (init_y),
    .ESchedX       (sched_x),
    .ESchedY       (sched_y),
    .ESchedFire    (fire),
    .EShipColl     (scoll),
    .EProjColl     (pcoll),
    .EShipOn       (EShipOn),
    .EShipDistX    (EShipDistX),
    .EShipDistY    (EShipDistY),
    .EProjOn       (EProjOn),
    .EProjDistX    (EProjDistX),
    .EProjDistY    (EProjDistY),
    .EShipAlive    (EShipAlive),
    .EProjDrop     (EProjDrop)
  );

  always #10 frame_clk = ~frame_clk;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  // Behavioural model state
  int m_mode [NS];
  int m_x [NS], m_y [NS], m_cnt [NS];
  bit m_live [NPE];
  int m_px [NPE], m_py [NPE];
  bit m_drop;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_mode[i] = M_ENTER; m_x[i] = int'(init_x); m_y[i] = int'(init_y); m_cnt[i] = 0;
    end
    for (int j = 0; j < NPE; j++) begin
      m_live[j] = 1'b0; m_px[j] = 0; m_py[j] = 0;
    end
    m_drop = 1'b0;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int toward(input int cur, input int tgt);
    if (tgt - cur > SHIP_STEP)  return cur + SHIP_STEP;
    if (tgt - cur < -SHIP_STEP) return cur - SHIP_STEP;
    return tgt;
  endfunction

  // One frame of the game rules, using the inputs present at the edge.
  function automatic void model_step();
    bit nl [NPE];
    bit taken [NPE];
    int npx [NPE], npy [NPE];
    bit drop;
    int slot, tx, ty;
    drop = 1'b0;
    for (int j = 0; j < NPE; j++) begin
      taken[j] = m_live[j];
      nl[j] = 1'b0; npx[j] = m_px[j]; npy[j] = m_py[j];
      if (m_live[j] && !pcoll[j] && (m_py[j] + PROJ_STEP <= BOTTOM)) begin
        nl[j] = 1'b1; npy[j] = m_py[j] + PROJ_STEP;
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (fire[i] && m_mode[i] == M_FORM) begin
        slot = -1;
        for (int j = 0; j < NPE; j++) if (slot < 0 && !taken[j]) slot = j;
        if (slot < 0) drop = 1'b1;
        else begin
          taken[slot] = 1'b1; nl[slot] = 1'b1;
          npx[slot] = (m_x[i] + SHIP_SIZE / 2 - PROJ_SIZE / 2) % 1024;
          npy[slot] = (m_y[i] + SHIP_SIZE) % 1024;
        end
      end
    end
    for (int i = 0; i < NS; i++) begin
      tx = int'(sched_x[i]); ty = int'(sched_y[i]);
      if (m_mode[i] == M_DEAD) begin
        if (m_cnt[i] == 0) begin
          m_mode[i] = M_ENTER; m_x[i] = int'(init_x); m_y[i] = int'(init_y);
        end else m_cnt[i]--;
      end else if (scoll[i]) begin
        m_mode[i] = M_DEAD; m_cnt[i] = RESPAWN - 1;
      end else if (m_mode[i] == M_FORM) begin
        m_x[i] = tx; m_y[i] = ty;
      end else begin
        if (iabs(tx - m_x[i]) <= SHIP_STEP && iabs(ty - m_y[i]) <= SHIP_STEP) begin
          m_x[i] = tx; m_y[i] = ty; m_mode[i] = M_FORM;
        end else begin
          m_x[i] = toward(m_x[i], tx); m_y[i] = toward(m_y[i], ty);
        end
      end
    end
    for (int j = 0; j < NPE; j++) begin
      m_live[j] = nl[j]; m_px[j] = npx[j]; m_py[j] = npy[j];
    end
    m_drop = drop;
  endfunction

  function automatic logic [NS-1:0] m_alive();
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++) v[i] = (m_mode[i] != M_DEAD);
    return v;
  endfunction

  function automatic bit inside_box(input int ox, input int oy, input int sz, input int x, input int y);
    return (x >= ox) && (x < ox + sz) && (y >= oy) && (y < oy + sz);
  endfunction

  function automatic logic [NS-1:0] m_ship_on(input int x, input int y);
    logic [NS-1:0] v;
    for (int i = 0; i < NS; i++)
      v[i] = (m_mode[i] != M_DEAD) && inside_box(m_x[i], m_y[i], SHIP_SIZE, x, y);
    return v;
  endfunction

  function automatic logic [NPE-1:0] m_proj_on(input int x, input int y);
    logic [NPE-1:0] v;
    for (int j = 0; j < NPE; j++) v[j] = m_live[j] && inside_box(m_px[j], m_py[j], PROJ_SIZE, x, y);
    return v;
  endfunction

  // Offset of the lowest-index hit, 10-bit modular; 0 when nothing is hit.
  function automatic int m_ship_dist(input int x, input int y, input bit use_y);
    logic [NS-1:0] on;
    on = m_ship_on(x, y);
    for (int i = 0; i < NS; i++)
      if (on[i]) return use_y ? ((y - m_y[i]) & 1023) : ((x - m_x[i]) & 1023);
    return 0;
  endfunction

  function automatic int m_proj_dist(input int x, input int y, input bit use_y);
    logic [NPE-1:0] on;
    on = m_proj_on(x, y);
    for (int j = 0; j < NPE; j++)
      if (on[j]) return use_y ? ((y - m_py[j]) & 1023) : ((x - m_px[j]) & 1023);
    return 0;
  endfunction

  // Per-frame comparison of every output against the model.
  always @(negedge frame_clk) begin
    int x, y;
    if (cmp_en) begin
      x = int'(DrawX); y = int'(DrawY);
      check("alive",     EShipAlive, m_alive());
      check("drop",      EProjDrop,  m_drop);
      check("ship_on",   EShipOn,    m_ship_on(x, y));
      check("ship_dx",   EShipDistX, m_ship_dist(x, y, 1'b0));
      check("ship_dy",   EShipDistY, m_ship_dist(x, y, 1'b1));
      check("proj_on",   EProjOn,    m_proj_on(x, y));
      check("proj_dx",   EProjDistX, m_proj_dist(x, y, 1'b0));
      check("proj_dy",   EProjDistY, m_proj_dist(x, y, 1'b1));
    end
  end

  task automatic step_frame();
    @(posedge frame_clk);
    model_step();
    #1;
  endtask

  task automatic probe(input int x, input int y);
    DrawX = 10'(x); DrawY = 10'(y);
    #1;
  endtask

  // Aim the raster near something interesting so on-tests get exercised.
  task automatic pick_probe();
    int live_idx [$];
    int k, x, y;
    x = $urandom_range(0, 639); y = $urandom_range(0, 479);
    case ($urandom_range(0, 2))
      0: begin
        for (int j = 0; j < NPE; j++) if (m_live[j]) live_idx.push_back(j);
        if (live_idx.size() > 0) begin
          k = live_idx[$urandom_range(0, live_idx.size() - 1)];
          x = m_px[k] + int'($urandom_range(0, PROJ_SIZE + 1)) - 1;
          y = m_py[k] + int'($urandom_range(0, PROJ_SIZE + 1)) - 1;
        end
      end
      1: begin
        k = $urandom_range(0, NS - 1);
        x = m_x[k] + int'($urandom_range(0, SHIP_SIZE + 1)) - 1;
        y = m_y[k] + int'($urandom_range(0, SHIP_SIZE + 1)) - 1;
      end
      default: ;
    endcase
    DrawX = 10'(x & 1023); DrawY = 10'(y & 1023);
  endtask

  initial begin
    int sx [$];
    int sy [$];
    Reset = 1'b1;
    init_x = 10'd100; init_y = 10'd0;
    fire = '0; scoll = '0; pcoll = '0;
    sched_x[0] = 10'd100; sched_y[0] = 10'd40;
    sched_x[1] = 10'd140; sched_y[1] = 10'd40;
    sched_x[2] = 10'd60;  sched_y[2] = 10'd40;
    sched_x[3] = 10'd120; sched_y[3] = 10'd40;
    DrawX = 10'd100; DrawY = 10'd0;
    model_reset();
    cmp_en = 1'b1;
    #1;
    // Reset state: all ships entering at the spawn point, no projectiles.
    check("rst_alive",   EShipAlive, 4'b1111);
    check("rst_ship_on", EShipOn,    4'b1111);
    check("rst_proj_on", EProjOn,    8'h00);
    check("rst_drop",    EProjDrop,  1'b0);
    @(negedge frame_clk); #3;
    Reset = 1'b0;

    // Entry: 20 frames to formation; a fire request on the last entry frame
    // comes from ENTER ships and is ignored.
    repeat (19) step_frame();
    fire = 4'b1111;
    step_frame();
    fire = '0;
    check("enter_fire_drop", EProjDrop, 1'b0);
    probe(106, 56);
    check("enter_fire_proj", EProjOn, 8'h00);
    probe(100, 39);
    check("form_above", EShipOn, 4'b0000);
    probe(100, 40);
    check("form_on",  EShipOn,    4'b0001);
    check("form_dx",  EShipDistX, 10'd0);

    // Three frames of all ships firing: 8 slots fill, third frame drops.
    fire = 4'b1111;
    step_frame();
    check("f1_drop", EProjDrop, 1'b0);
    probe(106, 56);
    check("f1_slot0", EProjOn, 8'h01);
    step_frame();
    check("f2_drop", EProjDrop, 1'b0);
    probe(106, 58);
    check("f2_slot4", EProjOn, 8'h10);
    check("f2_dy",    EProjDistY, 10'd2);
    step_frame();
    fire = '0;
    check("f3_drop", EProjDrop, 1'b1);
    probe(106, 64);
    check("f3_slot0_kept", EProjOn, 8'h01);
    step_frame();
    check("f4_drop", EProjDrop, 1'b0);

    // Slot 0 sits at y=64 after frame 3; 103 frames bring it to 476.
    repeat (102) step_frame();
    probe(106, 476);
    check("bottom_slot0", EProjOn, 8'h01);
    step_frame();
    probe(106, 476);
    check("bottom_slot4", EProjOn, 8'h10);
    step_frame();
    probe(106, 476);
    check("bottom_clear", EProjOn, 8'h00);
    fire = 4'b0001;
    step_frame();
    fire = '0;
    probe(106, 56);
    check("reuse_slot0", EProjOn, 8'h01);

    // Ship 2 hit: dead for 120 frames; a second hit while dead is ignored.
    scoll = 4'b0100;
    step_frame();
    scoll = '0;
    check("hit_alive", EShipAlive[2], 1'b0);
    repeat (59) step_frame();
    scoll = 4'b0100;
    step_frame();
    scoll = '0;
    repeat (59) step_frame();
    check("dead_119", EShipAlive[2], 1'b0);
    step_frame();
    check("respawn_alive", EShipAlive[2], 1'b1);
    probe(100, 0);
    check("respawn_on", EShipOn,    4'b0100);
    check("respawn_dy", EShipDistY, 10'd0);

    // Ships 0 and 1 overlapping at (200,100).
    sched_x[0] = 10'd200; sched_y[0] = 10'd100;
    sched_x[1] = 10'd200; sched_y[1] = 10'd100;
    step_frame();
    probe(205, 103);
    check("overlap_on", EShipOn,    4'b0011);
    check("overlap_dx", EShipDistX, 10'd5);
    check("overlap_dy", EShipDistY, 10'd3);

    // Launch several projectiles, then reset between edges.
    fire = 4'b1111;
    step_frame();
    step_frame();
    fire = '0;
    for (int j = 0; j < NPE; j++) if (m_live[j]) begin
      sx.push_back(m_px[j]); sy.push_back(m_py[j]);
    end
    probe(sx[0], sy[0]);
    check("pre_rst_proj", EProjOn, m_proj_on(sx[0], sy[0]));
    Reset = 1'b1;
    model_reset();
    #1;
    check("mid_rst_drop",  EProjDrop,  1'b0);
    check("mid_rst_alive", EShipAlive, 4'b1111);
    for (int k = 0; k < sx.size(); k++) begin
      probe(sx[k], sy[k]);
      check("mid_rst_proj", EProjOn, 8'h00);
    end
    @(negedge frame_clk); #3;
    Reset = 1'b0;

    // Randomized play against the model.
    for (int i = 0; i < NS; i++) begin
      sched_x[i] = 10'(80 + 130 * i); sched_y[i] = 10'd60;
    end
    for (int f = 0; f < 1500; f++) begin
      for (int i = 0; i < NS; i++) begin
        fire[i]  = ($urandom_range(0, 9) < 4);
        scoll[i] = ($urandom_range(0, 119) == 0);
        if ($urandom_range(0, 7) == 0) begin
          sched_x[i] = 10'(80 + 130 * i + int'($urandom_range(0, 6)) - 3);
          sched_y[i] = 10'(60 + int'($urandom_range(0, 6)) - 3);
        end
      end
      for (int j = 0; j < NPE; j++) pcoll[j] = ($urandom_range(0, 19) == 0);
      step_frame();
      pick_probe();
    end

    @(negedge frame_clk);
    #1;
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
